// File: rtl/spu_mastq_pkg.sv
// Shared types and sizing helpers for the MA-store sequencer.
// State encoding is one-hot; PTR_W/CNT_W give the default geometry.
package spu_mastq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_RUN   = 3'b010,
        ST_DRAIN = 3'b100
    } state_e;

    localparam int DEPTH_DEF = 4;
    localparam int PTR_W     = $clog2(DEPTH_DEF);
    localparam int CNT_W     = PTR_W + 1;

    // Counter width able to hold the value depth itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/spu_mastq_rdpipe.sv
// MA memory read-latency tracker: RD_LAT-stage valid shift register.
// Ports: clk, rst_l, flush (sync clear), rd in; wen strobe, infl count out.
module spu_mastq_rdpipe #(
    parameter int RD_LAT = 2,
    parameter int CW     = 3
) (
    input  logic          clk,
    input  logic          rst_l,
    input  logic          flush,
    input  logic          rd,
    output logic          wen,
    output logic [CW-1:0] infl
);

    logic [RD_LAT-1:0] vld;

    always_ff @(posedge clk) begin
        if (!rst_l || flush) begin
            vld <= '0;
        end else begin
            vld[0] <= rd;
            for (int i = 1; i < RD_LAT; i++) begin
                vld[i] <= vld[i-1];
            end
        end
    end

    // The stage leaving this cycle still counts: occ only picks it
    // up on the next edge.
    always_comb begin
        infl = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            infl = infl + CW'(vld[i]);
        end
    end

    assign wen = vld[RD_LAT-1];

endmodule

// File: rtl/spu_mastq.sv
// MA-store sequencer: streams LEN words from MA memory through a
// DEPTH-entry store buffer to LSU store requests, up to DEPTH in flight.
// Ports: rclk, rst_l, se; issue (iss_pulse, op_store, len_in); LSU
// (streq, streq_ack, stbuf_*); aborts (perr_set, force_abort);
// MA memory (memren, maaddr_addrinc); mpa_addrinc, busy, done_set.
module spu_mastq
    import spu_mastq_pkg::*;
#(
    parameter int LEN_W  = 6,
    parameter int DEPTH  = 4,
    parameter int RD_LAT = 2
) (
    input  logic                     rclk,
    input  logic                     rst_l,
    input  logic                     se,
    input  logic                     iss_pulse,
    input  logic                     op_store,
    input  logic [LEN_W-1:0]         len_in,
    input  logic                     streq_ack,
    input  logic                     perr_set,
    input  logic                     force_abort,
    input  logic                     allma_stacks_ok,
    output logic                     memren,
    output logic                     maaddr_addrinc,
    output logic                     stbuf_wen,
    output logic [$clog2(DEPTH)-1:0] stbuf_wptr,
    output logic [$clog2(DEPTH)-1:0] stbuf_rptr,
    output logic                     streq,
    output logic                     mpa_addrinc,
    output logic                     busy,
    output logic                     done_set
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

    state_e           state_q;
    state_e           state_d;
    logic [LEN_W-1:0] rem_q;
    logic [CW-1:0]    occ_q;
    logic [CW-1:0]    occ_nxt;
    logic [CW-1:0]    infl;
    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic             done_q;
    logic             done_dly_q;
    logic             mpa_q;

    logic is_idle;
    logic is_run;
    logic is_drain;
    logic stop;
    logic abort;
    logic start;
    logic start_zero;
    logic rd;
    logic wen_raw;
    logic wen;
    logic req;
    logic pop;
    logic drain_done;
    logic unused_se;

    assign unused_se = se;

    assign is_idle  = (state_q == ST_IDLE);
    assign is_run   = (state_q == ST_RUN);
    assign is_drain = (state_q == ST_DRAIN);

    assign stop  = perr_set | force_abort;
    assign abort = ~is_idle & stop;

    assign start      = is_idle & iss_pulse & op_store
                      & (len_in != '0);
    assign start_zero = is_idle & iss_pulse & op_store
                      & (len_in == '0);

    // Filled entries plus reads still in the pipe bound new reads.
    assign rd = is_run & (rem_q != '0) & ~abort
              & (({1'b0, occ_q} + {1'b0, infl}) < DEPTH_V);

    assign wen = wen_raw & ~is_idle & ~abort;
    assign req = ~is_idle & (occ_q != '0) & ~stop;
    assign pop = req & streq_ack;

    assign occ_nxt = occ_q + CW'(wen) - CW'(pop);

    // Look at next-cycle occupancy so IDLE follows the last ack directly.
    assign drain_done = is_drain & (occ_nxt == '0) & (infl == '0);

    spu_mastq_rdpipe #(
        .RD_LAT (RD_LAT),
        .CW     (CW)
    ) u_rdpipe (
        .clk   (rclk),
        .rst_l (rst_l),
        .flush (abort),
        .rd    (rd),
        .wen   (wen_raw),
        .infl  (infl)
    );

    always_ff @(posedge rclk) begin
        if (!rst_l) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (rd && rem_q == LEN_W'(1)) state_d = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (drain_done) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        memren         = rd;
        maaddr_addrinc = rd;
        stbuf_wen      = wen;
        streq          = req;
        busy           = ~is_idle;
        done_set       = done_q & done_dly_q & allma_stacks_ok;
    end

    assign stbuf_wptr  = wptr_q;
    assign stbuf_rptr  = rptr_q;
    assign mpa_addrinc = mpa_q;

    always_ff @(posedge rclk) begin
        if (!rst_l) begin
            rem_q      <= '0;
            occ_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            done_q     <= 1'b0;
            done_dly_q <= 1'b0;
            mpa_q      <= 1'b0;
        end else begin
            mpa_q      <= pop;
            done_dly_q <= done_q;
            if (start_zero || abort || drain_done) begin
                done_q <= 1'b1;
            end else if (iss_pulse) begin
                done_q <= 1'b0;
            end
            if (start) begin
                rem_q  <= len_in;
                occ_q  <= '0;
                wptr_q <= '0;
                rptr_q <= '0;
            end else if (abort) begin
                rem_q <= '0;
                occ_q <= '0;
            end else begin
                if (rd)  rem_q  <= rem_q - LEN_W'(1);
                if (wen) wptr_q <= wptr_q + PW'(1);
                if (pop) rptr_q <= rptr_q + PW'(1);
                occ_q <= occ_nxt;
            end
        end
    end

endmodule

// File: tb/tb_spu_mastq.sv
// Scoreboard bench for spu_mastq: expected buffer indices queued at
// issue, a negedge monitor checks every write and accepted ack.
module tb_spu_mastq;

    localparam int LEN_W  = 6;
    localparam int DEPTH  = 4;
    localparam int RD_LAT = 2;

    logic             rclk = 1'b0;
    logic             rst_l = 1'b0;
    logic             se = 1'b0;
    logic             iss_pulse = 1'b0;
    logic             op_store = 1'b0;
    logic [LEN_W-1:0] len_in = '0;
    logic             streq_ack = 1'b0;
    logic             perr_set = 1'b0;
    logic             force_abort = 1'b0;
    logic             allma_stacks_ok = 1'b1;
    logic             memren;
    logic             maaddr_addrinc;
    logic             stbuf_wen;
    logic [1:0]       stbuf_wptr;
    logic [1:0]       stbuf_rptr;
    logic             streq;
    logic             mpa_addrinc;
    logic             busy;
    logic             done_set;

    spu_mastq #(
        .LEN_W  (LEN_W),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT)
    ) dut (
        .rclk            (rclk),
        .rst_l           (rst_l),
        .se              (se),
        .iss_pulse       (iss_pulse),
        .op_store        (op_store),
        .len_in          (len_in),
        .streq_ack       (streq_ack),
        .perr_set        (perr_set),
        .force_abort     (force_abort),
        .allma_stacks_ok (allma_stacks_ok),
        .memren          (memren),
        .maaddr_addrinc  (maaddr_addrinc),
        .stbuf_wen       (stbuf_wen),
        .stbuf_wptr      (stbuf_wptr),
        .stbuf_rptr      (stbuf_rptr),
        .streq           (streq),
        .mpa_addrinc     (mpa_addrinc),
        .busy            (busy),
        .done_set        (done_set)
    );

    always #5 rclk = ~rclk;

    int cyc = 0;
    always @(posedge rclk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d cyc=%0d",
                     nm, act, exp, cyc);
        end
    endtask

    int wq[$];
    int rq[$];
    int n_memren, n_wen, n_ack, n_mpa, n_done;
    int first_memren, last_memren, first_streq;
    int last_ack, mpa_cyc, done_cyc, t_iss, b;
    logic done_prev = 1'b0;

    // LSU model: 0 never acks, 1 acks every cycle, 2 acks one cycle
    // after it saw streq.
    int   ack_mode = 0;
    logic s_prev = 1'b0;
    always @(negedge rclk) s_prev <= streq;
    initial forever begin
        @(posedge rclk);
        #1;
        streq_ack = (ack_mode == 1) ? 1'b1 :
                    (ack_mode == 2) ? s_prev : 1'b0;
    end

    // Monitor
    always @(negedge rclk) begin
        if (rst_l) begin
            if (memren) begin
                n_memren++;
                if (first_memren < 0) first_memren = cyc;
                last_memren = cyc;
                chk("addrinc", maaddr_addrinc, 1);
                chk("outstanding_le_depth",
                    int'((n_memren - n_ack) <= DEPTH), 1);
            end
            if (stbuf_wen) begin
                n_wen++;
                if (wq.size() == 0) chk("wen_unexpected", 0, 1);
                else chk("wptr", stbuf_wptr, wq.pop_front());
            end
            if (streq && first_streq < 0) first_streq = cyc;
            if (streq && streq_ack) begin
                n_ack++;
                last_ack = cyc;
                if (rq.size() == 0) chk("ack_unexpected", 0, 1);
                else chk("rptr", stbuf_rptr, rq.pop_front());
            end
            if (mpa_addrinc) begin
                n_mpa++;
                mpa_cyc = cyc;
            end
            if (done_set && !done_prev) begin
                n_done++;
                done_cyc = cyc;
            end
            done_prev = done_set;
        end
    end

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic clr();
        n_memren = 0; n_wen = 0; n_ack = 0; n_mpa = 0; n_done = 0;
        first_memren = -1; last_memren = -1; first_streq = -1;
        last_ack = -1; mpa_cyc = -1; done_cyc = -1;
        wq.delete();
        rq.delete();
    endtask

    task automatic issue(input int len);
        iss_pulse = 1'b1;
        op_store  = 1'b1;
        len_in    = LEN_W'(len);
        t_iss     = cyc;
        for (int k = 0; k < len; k++) begin
            wq.push_back(k % DEPTH);
            rq.push_back(k % DEPTH);
        end
        tick();
        iss_pulse = 1'b0;
        op_store  = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        bit ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge rclk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk({nm, "_reaches_idle"}, ok, 1);
        tick();
    endtask

    function automatic int outs();
        return int'({memren, maaddr_addrinc, stbuf_wen, streq,
                     mpa_addrinc, busy, done_set,
                     stbuf_wptr, stbuf_rptr});
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog_expired cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        repeat (3) tick();
        @(negedge rclk);
        chk("reset_outputs", outs(), 0);
        tick();
        rst_l = 1'b1;
        tick();

        // Abort while idle must not raise done
        force_abort = 1'b1;
        tick();
        force_abort = 1'b0;
        repeat (3) tick();
        chk("idle_abort_no_done", done_set, 0);

        // Length 1, ack one cycle after streq
        ack_mode = 2;
        clr();
        issue(1);
        wait_idle("len1", 40);
        repeat (3) tick();
        chk("len1_first_rd", first_memren - t_iss, 1);
        chk("len1_reads", n_memren, 1);
        chk("len1_wens", n_wen, 1);
        chk("len1_acks", n_ack, 1);
        chk("len1_mpa", n_mpa, 1);
        chk("len1_streq_lat", first_streq - first_memren, RD_LAT + 1);
        chk("len1_mpa_lat", mpa_cyc - last_ack, 1);
        chk("len1_done_lat", done_cyc - last_ack, 2);

        // Length 11, ack held high
        ack_mode = 1;
        clr();
        issue(11);
        wait_idle("len11", 60);
        repeat (3) tick();
        chk("len11_reads", n_memren, 11);
        chk("len11_acks", n_ack, 11);
        chk("len11_no_gap", last_memren - first_memren, 10);
        chk("len11_wptr", stbuf_wptr, 3);
        chk("len11_rptr", stbuf_rptr, 3);
        chk("len11_done_lat", done_cyc - last_ack, 2);

        // Length 8, LSU stalled for 20 cycles
        ack_mode = 0;
        clr();
        issue(8);
        repeat (20) tick();
        chk("stall_reads", n_memren, 4);
        chk("stall_wens", n_wen, 4);
        chk("stall_acks", n_ack, 0);
        chk("stall_busy", busy, 1);
        ack_mode = 1;
        wait_idle("stall", 60);
        repeat (3) tick();
        chk("stall_reads_all", n_memren, 8);
        chk("stall_acks_all", n_ack, 8);
        chk("stall_mpa_all", n_mpa, 8);
        chk("stall_done_lat", done_cyc - last_ack, 2);

        // Parity abort after three acks
        ack_mode = 1;
        clr();
        issue(8);
        for (int k = 0; k < 30; k++) begin
            if (n_ack >= 3) break;
            tick();
        end
        chk("abort_acks_seen", n_ack, 3);
        perr_set = 1'b1;
        b = cyc;
        @(negedge rclk);
        chk("abort_quiet", int'({memren, stbuf_wen, streq}), 0);
        tick();
        perr_set = 1'b0;
        @(negedge rclk);
        chk("abort_idle", busy, 0);
        repeat (4) tick();
        chk("abort_reads", n_memren, 6);
        chk("abort_no_late_rd", int'(last_memren < b), 1);
        chk("abort_done_lat", done_cyc - b, 2);
        wq.delete();
        rq.delete();

        // Completion with ack counters not yet drained
        allma_stacks_ok = 1'b0;
        clr();
        issue(2);
        wait_idle("allma", 40);
        repeat (5) tick();
        chk("allma_held_cnt", n_done, 0);
        chk("allma_held", done_set, 0);
        allma_stacks_ok = 1'b1;
        @(negedge rclk);
        chk("allma_release", done_set, 1);
        tick();

        // Non-store issue clears done, starts nothing
        iss_pulse = 1'b1;
        len_in    = LEN_W'(5);
        tick();
        iss_pulse = 1'b0;
        @(negedge rclk);
        chk("nonstore_clr_done", done_set, 0);
        chk("nonstore_idle", busy, 0);
        tick();

        // Zero length: done without any reads
        clr();
        issue(0);
        repeat (3) tick();
        chk("len0_reads", n_memren, 0);
        chk("len0_done_cnt", n_done, 1);
        chk("len0_done_lat", done_cyc - t_iss, 2);

        // Second issue clears done
        ack_mode = 1;
        clr();
        issue(2);
        @(negedge rclk);
        chk("reissue_clr_done", done_set, 0);
        wait_idle("reissue", 40);
        repeat (3) tick();
        chk("reissue_acks", n_ack, 2);
        chk("reissue_done_lat", done_cyc - last_ack, 2);

        // Reset in the middle of a run
        ack_mode = 0;
        clr();
        issue(8);
        repeat (5) tick();
        chk("prereset_active", int'({busy, streq}), 3);
        rst_l = 1'b0;
        tick();
        @(negedge rclk);
        chk("midrun_reset_outputs", outs(), 0);
        tick();
        rst_l = 1'b1;
        wq.delete();
        rq.delete();
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spu_mastq.md
# spu_mastq

Parametrised MA-store sequencer for the SPU: moves LEN words from MA scratch memory into a DEPTH-entry store buffer and issues store requests to L2 through the LSU. Up to DEPTH stores may be outstanding, where the previous generation allowed at most two. Sits between spu_mactl (issue, abort, parity) and the LSU store interface; reports completion to spu_mactl once spu_wen confirms all acks are in.

## Interface
- LEN_W, 6: width of word-count length operand
- DEPTH, 4: store-buffer entries / max outstanding store requests (power of 2, ≥2)
- RD_LAT, 2: cycles from memren to stbuf_wen (≥1)
- rclk  in  1  clock
- rst_l  in  1  reset; synchronous, active-low
- se  in  1  scan enable; no functional effect
- iss_pulse  in  1  one-cycle MA-op issue strobe
- op_store  in  1  issued op is a store (qualifies iss_pulse)
- len_in  in  LEN_W  word count, sampled on iss_pulse & op_store
- streq_ack  in  1  LSU accepted the current store request
- perr_set  in  1  MA memory parity error; abort
- force_abort  in  1  stxa-forced abort
- allma_stacks_ok  in  1  spu_wen: ack counters drained
- memren  out  1  MA memory read enable
- maaddr_addrinc  out  1  advance MA memory address (= memren)
- stbuf_wen  out  1  write store-buffer entry stbuf_wptr
- stbuf_wptr  out  log2(DEPTH)  store-buffer write index
- stbuf_rptr  out  log2(DEPTH)  entry presented with streq
- streq  out  1  store request to LSU
- mpa_addrinc  out  1  advance L2 physical address
- busy  out  1  FSM not IDLE
- done_set  out  1  store op complete, gated

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE→RUN on iss_pulse & op_store & len_in≠0; load rem=len_in, clear pointers and counters, and clear the done flag.
- With len_in=0, stay in IDLE and set the done flag directly.
- RUN issues a read (memren) when rem≠0 & ~abort & (occ+infl)<DEPTH, where:
  - occ counts filled, unacked entries (width log2(DEPTH)+1);
  - infl counts reads inside the RD_LAT pipe.
- Each read decrements rem. RUN→DRAIN when rem reaches 0.
- RD_LAT pipe delivers stbuf_wen. Each wen writes stbuf_wptr, then increments wptr (mod DEPTH) and occ.
- streq = busy & occ≠0 & ~perr_set & ~force_abort. This is a level request.
- Each streq_ack while streq is high pops one entry: rptr++ (mod DEPTH), occ−−.
- streq_ack while streq is low is ignored.
- The same-cycle wen and ack leave occ unchanged.
- DRAIN→IDLE when occ=0 & infl=0; set the done flag.
- Abort (perr_set|force_abort while busy):
  - next state is IDLE;
  - rem, occ, infl and the pipe are flushed;
  - streq and memren are low in the same cycle;
  - the done flag is set. It is not set if the abort arrives in IDLE.
- done flag is cleared by reset or iss_pulse. done_set = done_q & done_q_dly & allma_stacks_ok, where done_q_dly is done_q delayed one cycle.
- iss_pulse while busy is ignored.

## Timing
- Reset (rst_l=0 at an rclk edge): all outputs 0, state IDLE, all counters and pointers 0.
- Issue accepted at cycle t: busy from t+1, first memren at t+1.
- memren at cycle c gives stbuf_wen at c+RD_LAT; streq can rise at c+RD_LAT+1.
- mpa_addrinc pulses one cycle after each accepted ack.
- Sustained throughput is 1 word/cycle when the LSU acks every cycle and DEPTH ≥ RD_LAT+1.
- Last accepted ack at cycle a (in DRAIN):
  - IDLE and done_q at a+1;
  - done_set no earlier than a+2, and only while allma_stacks_ok=1.
- Abort at cycle b:
  - no memren, stbuf_wen or streq at b or later;
  - IDLE at b+1;
  - done_set no earlier than b+2.
- rem never underflows. occ+infl never exceeds DEPTH.

## Structure
- Shared package spu_mastq_pkg holds:
  - the state encoding (IDLE/RUN/DRAIN, one-hot);
  - localparams PTR_W=$clog2(DEPTH) and CNT_W=PTR_W+1.
- Sub-module spu_mastq_rdpipe: RD_LAT-stage valid shift register with synchronous flush. It outputs the wen strobe and the infl count.

## Test plan
- Length 1 (len_in=1, DEPTH=4, RD_LAT=2, ack 1 cycle after streq):
  - exactly one memren, one stbuf_wen and one streq;
  - mpa_addrinc once;
  - done_set at ack+2.
- Length 11 with ack held high:
  - 11 memren, 11 acks;
  - wptr/rptr wrap to 3;
  - no gap after fill.
- Length 8, no ack for 20 cycles:
  - memren stops after 4 reads (occ=4);
  - releasing ack drains all 8, in order.
- perr_set in RUN after 3 acks of 8:
  - streq low in the same cycle;
  - IDLE next cycle;
  - done_set asserts;
  - no further memren.
- allma_stacks_ok=0 at completion: done_set stays 0 until allma_stacks_ok rises, then goes high the same cycle.
- Boundary cases:
  - len_in=0: no memren, done flag set immediately;
  - a second iss_pulse clears done_set;
  - rst_l low mid-run returns all outputs to 0 at the next edge.
